// File: rtl/alu_arith_seq_if.sv
// Handshake and operand/result bundle for the chunked arithmetic ALU slice.
// Optional macro ALU_OVF_EN adds the two's-complement overflow flag v_o.
interface alu_arith_seq_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] op2_i;
    logic [1:0]       alu_op_i;
    logic             carry_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] res_o;
    logic             cout_o;
    logic             z_o;
`ifdef ALU_OVF_EN
    logic             v_o;
`endif

    modport master (
        output start_i, rs_i, op2_i, alu_op_i, carry_i,
        input  busy_o, done_o, res_o, cout_o, z_o
`ifdef ALU_OVF_EN
        , input v_o
`endif
    );

    modport slave (
        input  start_i, rs_i, op2_i, alu_op_i, carry_i,
        output busy_o, done_o, res_o, cout_o, z_o
`ifdef ALU_OVF_EN
        , output v_o
`endif
    );
endinterface

// File: rtl/alu_arith_seq.sv
// Multi-cycle add/addc/sub/subc ALU slice processing CHUNK bits per clock, LSB first.
// Optional macro ALU_OVF_EN enables the registered overflow flag v_o.
module alu_arith_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    alu_arith_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, sub_q, cout_q, z_q;
    logic             busy, done, accept, last, cin;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] acc_next;
`ifdef ALU_OVF_EN
    logic             v_q, msb_cin;
`endif

    assign accept = bus.start_i && (state_q != RUN);
    assign last   = (cnt_q == LAST);
    assign sum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

    // Result is assembled by shifting each new chunk in from the top.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign acc_next = sum[CHUNK-1:0];
        end else begin : g_multi
            assign acc_next = {sum[CHUNK-1:0], acc_q[WIDTH-1:CHUNK]};
        end
    endgenerate

`ifdef ALU_OVF_EN
    assign msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum[CHUNK-1];
`endif

    always_comb begin
        cin = 1'b0;
        case (bus.alu_op_i)
            2'b00:   cin = 1'b0;
            2'b01:   cin = bus.carry_i;
            2'b10:   cin = 1'b1;
            default: cin = ~bus.carry_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = bus.start_i ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands shift right so the active chunk always sits in the low bits.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
`ifdef ALU_OVF_EN
            v_q     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= bus.rs_i;
            b_q     <= bus.alu_op_i[1] ? ~bus.op2_i : bus.op2_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= cin;
            sub_q   <= bus.alu_op_i[1];
        end else if (state_q == RUN) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            acc_q   <= acc_next;
            carry_q <= sum[CHUNK];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                res_q  <= acc_next;
                cout_q <= sum[CHUNK] ^ sub_q;
                z_q    <= (acc_next == '0);
`ifdef ALU_OVF_EN
                v_q    <= msb_cin ^ sum[CHUNK];
`endif
            end
        end
    end

    assign bus.busy_o = busy;
    assign bus.done_o = done;
    assign bus.res_o  = res_q;
    assign bus.cout_o = cout_q;
    assign bus.z_o    = z_q;
`ifdef ALU_OVF_EN
    assign bus.v_o    = v_q;
`endif
endmodule

// File: doc/alu_arith_seq.md
Name: alu_arith_seq

Overview:
Parametrised, multi-cycle successor to the Gumnut 8-bit arithmetic ALU slice.
- Performs add, add-with-carry, subtract and subtract-with-borrow over WIDTH bits.
- Processes CHUNK bits per clock, LSB chunk first, with a start/busy/done handshake.
- Registers the result, carry/borrow and zero flags.
- Sits beside the combinational logic unit in the core datapath; the control FSM stalls on busy_o.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per clock; NCHUNK = WIDTH/CHUNK; legal range 1..WIDTH.

Ports:
- clk_i  in  1  rising-edge clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  request; accepted only when busy_o=0
- rs_i  in  WIDTH  operand A
- op2_i  in  WIDTH  operand B
- alu_op_i  in  2  00 add, 01 addc, 10 sub, 11 subc
- carry_i  in  1  carry flag from status register
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse; result valid
- res_o  out  WIDTH  result
- cout_o  out  1  carry (add) / borrow (sub)
- z_o  out  1  result == 0

Behaviour:
- Reset values (async, rst_n_i=0): state IDLE; busy_o=0, done_o=0, res_o=0, cout_o=0, z_o=0; internal count, shift registers and carry cleared.
- States:
  - IDLE: busy_o=0.
  - RUN: busy_o=1.
  - DONE: busy_o=0, done_o=1, lasts exactly one cycle.
- Accept: start_i=1 at an edge while in IDLE or DONE.
  - Latch A=rs_i.
  - Latch B=op2_i, or ~op2_i when alu_op_i[1]=1.
  - Initial carry cin:
    - add: 0
    - addc: carry_i
    - sub: 1
    - subc: ~carry_i
  - Latch alu_op_i[1]; set count=0; go to RUN.
- Back-to-back: start_i in the DONE cycle is accepted; next state is RUN.
- RUN, each edge:
  - Add chunk[count] of A and B plus the running carry, CHUNK+1 bits wide.
  - Place the sum chunk into result bits [count*CHUNK +: CHUNK].
  - The running carry becomes bit CHUNK of the sum; count increments.
  - On the edge processing chunk NCHUNK-1:
    - res_o updates with the full result.
    - cout_o = final carry XOR latched alu_op_i[1] (borrow polarity for sub/subc).
    - z_o = (result == 0).
    - Go to DONE.
- Latency: start sampled at edge 0 → res_o/flags/done_o visible after edge NCHUNK; done_o drops after edge NCHUNK+1 unless the new op also finishes then (impossible, NCHUNK≥1).
- res_o, cout_o, z_o hold their values until the next completion; they do not change during RUN. Partial sums stay internal.
- Input changes during RUN have no effect (operands were latched at accept).
- start_i while in RUN is ignored and not queued.
- carry_i is sampled only at accept.
- CHUNK=WIDTH: single RUN cycle, latency 1.
- Carry chain wraps modulo 2^WIDTH; no saturation.
- Reset mid-operation aborts immediately to IDLE with all outputs cleared; no done_o is produced.

Optional Feature:
Macro ALU_OVF_EN.
- Defined:
  - Adds output port v_o (1 bit, resets to 0).
  - v_o = two's-complement overflow: carry into MSB XOR carry out of MSB, taken before borrow inversion.
  - Updated together with cout_o; held otherwise.
- Undefined: no v_o port and no MSB carry-in tracking logic.

Test Plan:
- WIDTH=8, CHUNK=4: add rs=0x3C, op2=0x0F → after edge 2: res=0x4B, cout=0, z=0, done_o high one cycle, busy_o high during cycles 1–2.
- addc rs=0xFF, op2=0x00, carry_i=1 → res=0x00, cout=1, z=1.
- sub rs=0x10, op2=0x20 → res=0xF0, cout=1 (borrow). subc rs=0x50, op2=0x20, carry_i=1 → res=0x2F, cout=0.
- start_i held high and rs_i changed during RUN → result matches the operands latched at accept; a second start issued in the DONE cycle completes 2 edges later.
- Assert rst_n_i low after edge 1 of an add → all outputs 0 immediately, no done_o. Then WIDTH=16, CHUNK=1: add 0xFFFF+0x0001 → done after 16 edges, res=0x0000, cout=1, z=1.
- ALU_OVF_EN defined: add 0x7F+0x01 → res=0x80, v_o=1; sub 0x80−0x01 → res=0x7F, v_o=1; add 0x01+0x01 → v_o=0.
